// File: rtl/cbfp_stage1_if.sv
// Stream bundle between the stage-1 butterfly output and the CBFP renormaliser.
// The producer holds master; cbfp_stage1 takes slave.
interface cbfp_stage1_if #(
   parameter int IN_WIDTH  = 25,
   parameter int OUT_WIDTH = 11,
   parameter int LANES     = 16
);
   localparam int IDX_W = $clog2(IN_WIDTH);

   logic signed [IN_WIDTH-1:0]  din_re  [LANES];
   logic signed [IN_WIDTH-1:0]  din_im  [LANES];
   logic                        din_valid;
   logic signed [OUT_WIDTH-1:0] dout_re [LANES];
   logic signed [OUT_WIDTH-1:0] dout_im [LANES];
   logic                        dout_valid;
   logic [IDX_W-1:0]            dout_index;

   modport master (
      output din_re, din_im, din_valid,
      input  dout_re, dout_im, dout_valid, dout_index
   );

   modport slave (
      input  din_re, din_im, din_valid,
      output dout_re, dout_im, dout_valid, dout_index
   );
endinterface

// File: rtl/cbfp_stage1.sv
// Convergent block floating point after FFT stage 1: ping-pong buffers 64-point blocks,
// finds the smallest redundant-sign-bit count and renormalises each block to OUT_WIDTH bits.
module cbfp_stage1 #(
   parameter int IN_WIDTH  = 25,
   parameter int OUT_WIDTH = 11,
   parameter int LANES     = 16,
   parameter int BLK_BEATS = 4
) (
   input logic          clk,
   input logic          rstn,
   cbfp_stage1_if.slave bus
);
   localparam int IDX_W  = $clog2(IN_WIDTH);
   localparam int BEAT_W = $clog2(BLK_BEATS);
   localparam logic [IDX_W-1:0]  MAX_RSB   = IDX_W'(IN_WIDTH - 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_BEATS - 1);

   typedef logic signed [IN_WIDTH-1:0] sample_t;
   typedef enum logic {IDLE, DRAIN} state_t;

   sample_t            mem_re [2][BLK_BEATS][LANES];
   sample_t            mem_im [2][BLK_BEATS][LANES];
   logic [BEAT_W-1:0]  wr_cnt;
   logic               wr_bank;
   logic [IDX_W-1:0]   run_min;
   logic [IDX_W-1:0]   beat_min;
   logic [IDX_W-1:0]   blk_min;
   logic               block_end;
   state_t             state;
   logic [BEAT_W-1:0]  drain_cnt;
   logic               rd_bank;
   logic [IDX_W-1:0]   blk_shift;

   // Count the bits below the MSB that still copy the sign, stopping at the first difference.
   function automatic logic [IDX_W-1:0] rsb(input sample_t x);
      logic [IDX_W-1:0] cnt;
      logic             run;
      cnt = '0;
      run = 1'b1;
      for (int i = IN_WIDTH - 2; i >= 0; i--) begin
         if (run && (x[i] == x[IN_WIDTH-1])) cnt = cnt + IDX_W'(1);
         else                                run = 1'b0;
      end
      return cnt;
   endfunction

   // Left shift cannot overflow because the shift never exceeds the sample's own rsb.
   function automatic logic signed [OUT_WIDTH-1:0] scale(input sample_t x, input logic [IDX_W-1:0] sh);
      sample_t t;
      t = x <<< sh;
      return t[IN_WIDTH-1 -: OUT_WIDTH];
   endfunction

   always_comb begin
      beat_min = MAX_RSB;
      for (int l = 0; l < LANES; l++) begin
         if (rsb(bus.din_re[l]) < beat_min) beat_min = rsb(bus.din_re[l]);
         if (rsb(bus.din_im[l]) < beat_min) beat_min = rsb(bus.din_im[l]);
      end
      blk_min   = (run_min < beat_min) ? run_min : beat_min;
      block_end = bus.din_valid && (wr_cnt == LAST_BEAT);
   end

   always_ff @(posedge clk) begin
      if (bus.din_valid) begin
         for (int l = 0; l < LANES; l++) begin
            mem_re[wr_bank][wr_cnt][l] <= bus.din_re[l];
            mem_im[wr_bank][wr_cnt][l] <= bus.din_im[l];
         end
      end
   end

   // Fill side: the running minimum restarts with every block so blocks never influence each other.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_cnt  <= '0;
         wr_bank <= 1'b0;
         run_min <= MAX_RSB;
      end else if (bus.din_valid) begin
         if (block_end) begin
            wr_cnt  <= '0;
            wr_bank <= ~wr_bank;
            run_min <= MAX_RSB;
         end else begin
            wr_cnt  <= wr_cnt + BEAT_W'(1);
            run_min <= blk_min;
         end
      end
   end

   // Drain side: a block end landing on the final drain beat restarts the drain with no bubble.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state          <= IDLE;
         drain_cnt      <= '0;
         rd_bank        <= 1'b0;
         blk_shift      <= '0;
         bus.dout_valid <= 1'b0;
         bus.dout_index <= '0;
         for (int l = 0; l < LANES; l++) begin
            bus.dout_re[l] <= '0;
            bus.dout_im[l] <= '0;
         end
      end else begin
         bus.dout_valid <= 1'b0;
         if (state == DRAIN) begin
            for (int l = 0; l < LANES; l++) begin
               bus.dout_re[l] <= scale(mem_re[rd_bank][drain_cnt][l], blk_shift);
               bus.dout_im[l] <= scale(mem_im[rd_bank][drain_cnt][l], blk_shift);
            end
            bus.dout_valid <= 1'b1;
            bus.dout_index <= blk_shift;
            drain_cnt      <= drain_cnt + BEAT_W'(1);
            if (drain_cnt == LAST_BEAT) state <= IDLE;
         end
         if (block_end) begin
            state     <= DRAIN;
            drain_cnt <= '0;
            rd_bank   <= wr_bank;
            blk_shift <= blk_min;
         end
      end
   end
endmodule

// File: tb/tb_cbfp_stage1.sv
// Randomised and directed bench for cbfp_stage1 against a cycle-tagged block-level model.
module tb_cbfp_stage1;
   localparam int IN_WIDTH  = 25;
   localparam int OUT_WIDTH = 11;
   localparam int LANES     = 16;
   localparam int BLK_BEATS = 4;
   localparam int SHR       = IN_WIDTH - OUT_WIDTH;

   typedef struct packed {
      int                                edgeNo;
      int                                beat;
      int                                idx;
      logic [LANES-1:0][OUT_WIDTH-1:0]   re;
      logic [LANES-1:0][OUT_WIDTH-1:0]   im;
   } exp_t;

   logic clk  = 1'b0;
   logic rstn = 1'b1;
   always #5 clk = ~clk;

   cbfp_stage1_if #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .LANES(LANES)) bus ();

   cbfp_stage1 #(
      .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .LANES(LANES), .BLK_BEATS(BLK_BEATS)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int   checkCount = 0;
   int   passCount  = 0;
   exp_t expQ[$];
   int   edgeNo = 0;
   int   nBeats = 0;
   int   blkRe [BLK_BEATS][LANES];
   int   blkIm [BLK_BEATS][LANES];
   int   blockEndEdge = 0;
   int   stRe [LANES];
   int   stIm [LANES];

   int   lastIdx = 0;
   int   lastRe [LANES];
   int   lastIm [LANES];
   int   obsIdx = 0;
   int   obsRe [BLK_BEATS][LANES];
   int   obsIm [BLK_BEATS][LANES];
   int   firstValidEdge = 0;
   int   validCount = 0;
   int   runLen = 0;
   int   maxRun = 0;

   task automatic checkOutput(input string name, input longint got, input longint want);
      checkCount++;
      if (got == want) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
   endtask

   // Sign bits beyond the magnitude: 24 minus the number of magnitude bits.
   function automatic int rsbModel(input int x);
      int v;
      int n;
      v = (x < 0) ? ~x : x;
      n = 0;
      while (v != 0) begin
         v = v >> 1;
         n++;
      end
      return (IN_WIDTH - 1) - n;
   endfunction

   function automatic int scaleModel(input int x, input int sh);
      longint p;
      p = longint'(x) * (longint'(1) << sh);
      return int'(p >>> SHR);
   endfunction

   task automatic computeBlock(input int endEdge);
      int   sh;
      exp_t e;
      sh = IN_WIDTH - 1;
      for (int k = 0; k < BLK_BEATS; k++)
         for (int l = 0; l < LANES; l++) begin
            if (rsbModel(blkRe[k][l]) < sh) sh = rsbModel(blkRe[k][l]);
            if (rsbModel(blkIm[k][l]) < sh) sh = rsbModel(blkIm[k][l]);
         end
      for (int k = 0; k < BLK_BEATS; k++) begin
         e.edgeNo = endEdge + 1 + k;
         e.beat   = k;
         e.idx    = sh;
         for (int l = 0; l < LANES; l++) begin
            e.re[l] = OUT_WIDTH'(scaleModel(blkRe[k][l], sh));
            e.im[l] = OUT_WIDTH'(scaleModel(blkIm[k][l], sh));
         end
         expQ.push_back(e);
      end
   endtask

   // Reference model: collects accepted beats and schedules each block's drain one edge later.
   always @(posedge clk) begin
      edgeNo++;
      if (!rstn) begin
         nBeats = 0;
         expQ.delete();
      end else if (bus.din_valid === 1'b1) begin
         for (int l = 0; l < LANES; l++) begin
            blkRe[nBeats][l] = int'(bus.din_re[l]);
            blkIm[nBeats][l] = int'(bus.din_im[l]);
         end
         nBeats++;
         if (nBeats == BLK_BEATS) begin
            computeBlock(edgeNo);
            blockEndEdge = edgeNo;
            nBeats = 0;
         end
      end
   end

   // Compare every cycle: scheduled beats must appear exactly on their edge, otherwise outputs hold.
   always begin
      exp_t e;
      int   nDiff;
      @(posedge clk);
      #3;
      if (!rstn) begin
         nDiff = 0;
         for (int l = 0; l < LANES; l++)
            if (bus.dout_re[l] != 0 || bus.dout_im[l] != 0) nDiff++;
         checkOutput("reset valid", bus.dout_valid, 0);
         checkOutput("reset index", bus.dout_index, 0);
         checkOutput("reset data nonzero lanes", nDiff, 0);
         lastIdx = 0;
         for (int l = 0; l < LANES; l++) begin
            lastRe[l] = 0;
            lastIm[l] = 0;
         end
         runLen = 0;
      end else if (expQ.size() > 0 && expQ[0].edgeNo == edgeNo) begin
         e = expQ.pop_front();
         checkOutput("drain valid", bus.dout_valid, 1);
         checkOutput("drain index", bus.dout_index, e.idx);
         for (int l = 0; l < LANES; l++) begin
            checkOutput($sformatf("beat%0d re lane%0d", e.beat, l), int'(bus.dout_re[l]), int'($signed(e.re[l])));
            checkOutput($sformatf("beat%0d im lane%0d", e.beat, l), int'(bus.dout_im[l]), int'($signed(e.im[l])));
            lastRe[l] = int'(bus.dout_re[l]);
            lastIm[l] = int'(bus.dout_im[l]);
            obsRe[e.beat][l] = int'(bus.dout_re[l]);
            obsIm[e.beat][l] = int'(bus.dout_im[l]);
         end
         lastIdx = int'(bus.dout_index);
         obsIdx  = int'(bus.dout_index);
         if (e.beat == 0) firstValidEdge = edgeNo;
      end else begin
         nDiff = 0;
         for (int l = 0; l < LANES; l++)
            if (int'(bus.dout_re[l]) != lastRe[l] || int'(bus.dout_im[l]) != lastIm[l]) nDiff++;
         checkOutput("idle valid", bus.dout_valid, 0);
         checkOutput("idle index hold", bus.dout_index, lastIdx);
         checkOutput("idle data changed lanes", nDiff, 0);
      end
      if (bus.dout_valid === 1'b1) begin
         validCount++;
         runLen++;
         if (runLen > maxRun) maxRun = runLen;
      end else begin
         runLen = 0;
      end
   end

   task automatic applyStimulus();
      @(negedge clk);
      bus.din_valid = 1'b1;
      for (int l = 0; l < LANES; l++) begin
         bus.din_re[l] = IN_WIDTH'(stRe[l]);
         bus.din_im[l] = IN_WIDTH'(stIm[l]);
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.din_valid = 1'b0;
      end
   endtask

   task automatic fillAll(input int v);
      for (int l = 0; l < LANES; l++) begin
         stRe[l] = v;
         stIm[l] = v;
      end
   endtask

   function automatic int randSample(input int maxw);
      int w;
      int t;
      w = $urandom_range(maxw, 1);
      t = int'($urandom());
      return (t <<< (32 - w)) >>> (32 - w);
   endfunction

   initial begin
      int vc;
      int maxw;
      bus.din_valid = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         bus.din_re[l] = '0;
         bus.din_im[l] = '0;
      end
      #2 rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      idleCycles(2);

      // All +1: index 23, every output 512, one cycle of latency.
      fillAll(1);
      repeat (BLK_BEATS) applyStimulus();
      idleCycles(8);
      checkOutput("t1 index", obsIdx, 23);
      checkOutput("t1 beat2 re lane5", obsRe[2][5], 512);
      checkOutput("t1 beat3 im lane15", obsIm[3][15], 512);
      checkOutput("t1 latency", firstValidEdge - blockEndEdge, 1);

      // Full-scale negative forces shift 0; small positives floor to 0.
      for (int k = 0; k < BLK_BEATS; k++) begin
         fillAll(16383);
         if (k == 2) stRe[0] = -(1 << 24);
         applyStimulus();
      end
      idleCycles(8);
      checkOutput("t2 index", obsIdx, 0);
      checkOutput("t2 big component", obsRe[2][0], -1024);
      checkOutput("t2 small re", obsRe[2][1], 0);
      checkOutput("t2 small im", obsIm[2][0], 0);

      // All-zero block: maximum shift, exactly four valid cycles.
      vc = validCount;
      fillAll(0);
      repeat (BLK_BEATS) applyStimulus();
      idleCycles(8);
      checkOutput("t3 index", obsIdx, 24);
      checkOutput("t3 data", obsRe[1][3], 0);
      checkOutput("t3 valid cycles", validCount - vc, 4);

      // Single 256 component: shift 15, value 512.
      for (int k = 0; k < BLK_BEATS; k++) begin
         fillAll(0);
         if (k == 1) stIm[7] = 256;
         applyStimulus();
      end
      idleCycles(8);
      checkOutput("t4a index", obsIdx, 15);
      checkOutput("t4a component", obsIm[1][7], 512);
      checkOutput("t4a other", obsRe[1][7], 0);

      // Two blocks back to back; second all -1 must drain with no gap after the first.
      for (int k = 0; k < BLK_BEATS; k++) begin
         fillAll(0);
         if (k == 1) stIm[7] = 256;
         applyStimulus();
      end
      fillAll(-1);
      repeat (BLK_BEATS) applyStimulus();
      idleCycles(10);
      checkOutput("t4b index", obsIdx, 24);
      checkOutput("t4b value", obsRe[0][0], -1024);
      checkOutput("t4b contiguous run", maxRun, 8);

      // Random blocks with 1-3 cycle gaps between beats.
      for (int b = 0; b < 20; b++) begin
         maxw = $urandom_range(IN_WIDTH, 1);
         for (int k = 0; k < BLK_BEATS; k++) begin
            for (int l = 0; l < LANES; l++) begin
               stRe[l] = randSample(maxw);
               stIm[l] = randSample(maxw);
            end
            applyStimulus();
            idleCycles($urandom_range(3, 1));
         end
      end
      idleCycles(10);

      // Partial block discarded by reset, then a fresh block.
      fillAll(-(1 << 20));
      applyStimulus();
      applyStimulus();
      idleCycles(1);
      rstn = 1'b0;
      idleCycles(3);
      rstn = 1'b1;
      idleCycles(2);
      vc = validCount;
      fillAll(1000);
      repeat (BLK_BEATS) applyStimulus();
      idleCycles(8);
      checkOutput("t6 index", obsIdx, 14);
      checkOutput("t6 value", obsIm[2][9], 1000);
      checkOutput("t6 valid cycles", validCount - vc, 4);

      checkOutput("pending expected beats", expQ.size(), 0);
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
